rom_arbiter: RTL
================

Name: rom_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one shared 32x8 synchronous ROM (1-cycle registered read).
- Accepts independent read requests from two clients, drives the ROM address, absorbs the ROM read latency, and returns each client's byte with a one-cycle valid pulse.
- Sits between the ROM instance and two consumers, e.g. a display driver and a UART message sender.

Parameters:
- ADDR_W, 5, ROM address width (32 locations).
- DATA_W, 8, ROM data width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  port 0 read request, level.
- addr0  input  ADDR_W  port 0 read address; held stable while req0=1 until gnt0.
- gnt0  output  1  one-cycle pulse: port 0 address accepted.
- rdata0  output  DATA_W  port 0 read data; valid when vld0=1, held until the next port 0 completion.
- vld0  output  1  one-cycle pulse: rdata0 updated.
- req1, addr1, gnt1, rdata1, vld1: same as port 0, for port 1.
- rom_addr  output  ADDR_W  registered address to the ROM's addr input.
- rom_data  input  DATA_W  from the ROM data_out.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=IDLE; gnt0, gnt1, vld0, vld1, busy = 0.
  - rdata0, rdata1, rom_addr = 0.
  - last-granted pointer = 1, so port 0 wins the first tie.
- Reset asserted mid-transaction aborts it: no vld is ever issued for the aborted read.
- FSM states: IDLE, READ, CAPT.
- IDLE:
  - req0 and req1 are sampled only in this state.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant that port.
  - If both are high, grant the port that is not the last-granted one.
  - On a grant at edge k: rom_addr <= winner's address; gnt_winner=1 for the cycle after edge k; the pointer is updated to the winner; the winner is latched; state <= READ.
- READ: the ROM captures mem[rom_addr] at edge k+1. state <= CAPT.
- CAPT: at edge k+2, rdata_winner <= rom_data and vld_winner=1 for one cycle. state <= IDLE.
- rom_addr holds its value outside grants; it is not cleared after a read.
- Latency: req sampled at edge k gives vld high in the cycle after edge k+2, which is 3 cycles.
- Throughput: at most one read every 3 cycles. The next grant can occur at edge k+3.
- Request consumption:
  - The request is consumed at the grant; the requester must drop req before the next IDLE sample (edge k+3).
  - If req is still high at the next IDLE edge, it is a new request.
  - addr may change any time after the gnt pulse.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1,… No port waits more than one transaction.
- Requests arriving while busy=1 are not sampled and not lost. They are serviced when IDLE, provided req stays high.
- The non-winning port's rdata and vld are unchanged during a transaction.
- gnt and vld never assert for both ports in the same cycle.
- No width conversion. addr passes straight through to rom_addr, and rom_data straight through to rdata.

Test Plan (bench ROM model: 1-cycle registered read, mem[a] = a + 8'h10):
- Reset then single read: req0=1, addr0=5 sampled at edge 0 -> gnt0 after edge 0, rom_addr=5, vld0 after edge 2, rdata0=8'h15; port 1 outputs stay 0.
- Simultaneous first request: req0=1/addr0=3, req1=1/addr1=7 at the same edge after reset -> port 0 served first (rdata0=8'h13), then port 1 granted at edge 3 with rdata1=8'h17 three cycles later.
- Continuous contention: both ports hold req for 12 cycles with distinct addresses -> grant order 0,1,0,1; one vld every 3 cycles; data correct per port.
- Boundary addresses: addr1=0, then addr1=31 -> rdata1=8'h10, then rdata1=8'h2F; rom_addr wraps nothing and is taken exactly as given.
- Request during busy: req1 rises in READ while port 0 is in flight -> port 1 not granted until the next IDLE edge; port 0 data unaffected.
- Reset mid-op: assert rst_n=0 during CAPT -> all outputs 0 immediately, no vld pulse; after release, req1=1/addr1=2 completes with rdata1=8'h12 and port 0 keeps first-tie priority.

Source files
------------

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_arbiter
// Purpose  : Two-port round-robin arbiter and read sequencer for a single
//            shared synchronous ROM with a 1-cycle registered read.
//            Grants one request at a time, drives the ROM address, waits for
//            the ROM read latency, and returns the byte to the winning port
//            with a one-cycle valid pulse.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            req0/addr0       - port 0 level request and address
//            gnt0             - port 0 address-accepted pulse
//            rdata0/vld0      - port 0 read data and update pulse
//            req1/addr1/gnt1/rdata1/vld1 - same for port 1
//            rom_addr         - registered address to the ROM
//            rom_data         - data returned by the ROM
//            busy             - high while a transaction is in flight
// Revision : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              vld0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              vld1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;

    logic [1:0] r_state;
    logic       r_last;   // port granted most recently (1 after reset so port 0 wins first tie)
    logic       r_win;    // port owning the transaction in flight
    logic       w_any;
    logic       w_pick;   // port that would be granted this cycle (0 or 1)

    // On a tie the port that was not granted last wins; with a single
    // requester, that requester wins. w_pick is only used when w_any is set.
    always_comb begin
        w_any  = req0 | req1;
        w_pick = 1'b0;
        if (req0 && req1) begin
            w_pick = ~r_last;
        end else begin
            w_pick = ~req0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_last   <= 1'b1;
            r_win    <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            vld0     <= 1'b0;
            vld1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            rom_addr <= '0;
        end else begin
            // Pulses last exactly one cycle unless re-set below.
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            vld0 <= 1'b0;
            vld1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        rom_addr <= w_pick ? addr1 : addr0;
                        gnt0     <= ~w_pick;
                        gnt1     <= w_pick;
                        r_last   <= w_pick;
                        r_win    <= w_pick;
                        r_state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    // ROM registers mem[rom_addr] on this edge.
                    r_state <= ST_CAPT;
                end
                ST_CAPT: begin
                    if (r_win) begin
                        rdata1 <= rom_data;
                        vld1   <= 1'b1;
                    end else begin
                        rdata0 <= rom_data;
                        vld0   <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
